// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder for the MEM stage
module dmem_responder #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        halt,
    output logic        stall,
    output logic        done,
    output logic [15:0] rdata,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP,
        S_HALTED
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                cap_rd_q, cap_rd_d;
    logic                cap_wr_q, cap_wr_d;
    logic [ADDR_W-1:0]   cap_idx_q, cap_idx_d;
    logic [15:0]         cap_wdata_q, cap_wdata_d;
    logic                halt_seen_q, halt_seen_d;
    logic [15:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [15:0]         mem [0:(1<<ADDR_W)-1];

    logic [ADDR_W-1:0]   req_idx;
    logic                accept;
    logic                req_bad;
    logic                commit_wr;
    logic                commit_rd;
    logic [ADDR_W-1:0]   commit_idx;
    logic [15:0]         commit_wdata;
    logic                unused_addr;

    // High address bits are don't-care: addresses differing only there alias.
    assign req_idx     = req_addr[ADDR_W:1];
    assign unused_addr = ^req_addr[15:ADDR_W+1];
    assign accept      = (req_rd ^ req_wr) & ~req_addr[0];
    assign req_bad     = (req_rd & req_wr) | ((req_rd | req_wr) & req_addr[0]);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_rd_d     = cap_rd_q;
        cap_wr_d     = cap_wr_q;
        cap_idx_d    = cap_idx_q;
        cap_wdata_d  = cap_wdata_q;
        halt_seen_d  = halt_seen_q;
        err_d        = err_q;
        stall        = 1'b0;
        done         = 1'b0;
        commit_wr    = 1'b0;
        commit_rd    = 1'b0;
        commit_idx   = cap_idx_q;
        commit_wdata = cap_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stall       = 1'b1;
                    cap_rd_d    = req_rd;
                    cap_wr_d    = req_wr;
                    cap_idx_d   = req_idx;
                    cap_wdata_d = req_wdata;
                    cnt_d       = 4'(LATENCY - 1);
                    halt_seen_d = halt;
                    if (LATENCY == 1) begin
                        // Single-cycle access commits straight from the request inputs.
                        state_d      = S_RESP;
                        commit_wr    = req_wr;
                        commit_rd    = req_rd;
                        commit_idx   = req_idx;
                        commit_wdata = req_wdata;
                    end else begin
                        state_d = S_BUSY;
                    end
                end else begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end
                    if (halt) begin
                        state_d = S_HALTED;
                    end
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (halt) begin
                    halt_seen_d = 1'b1;
                end
                if (cnt_q == 4'd1) begin
                    state_d   = S_RESP;
                    commit_wr = cap_wr_q;
                    commit_rd = cap_rd_q;
                end
            end
            S_RESP: begin
                done        = 1'b1;
                halt_seen_d = 1'b0;
                cap_rd_d    = 1'b0;
                cap_wr_d    = 1'b0;
                state_d     = (halt || halt_seen_q) ? S_HALTED : S_IDLE;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (commit_rd) begin
            rdata_d = mem[commit_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            cap_rd_q    <= 1'b0;
            cap_wr_q    <= 1'b0;
            cap_idx_q   <= '0;
            cap_wdata_q <= 16'd0;
            halt_seen_q <= 1'b0;
            rdata_q     <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_rd_q    <= cap_rd_d;
            cap_wr_q    <= cap_wr_d;
            cap_idx_q   <= cap_idx_d;
            cap_wdata_q <= cap_wdata_d;
            halt_seen_q <= halt_seen_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Storage is not reset; gating on rst keeps a write from landing while reset is held.
    always_ff @(posedge clk) begin
        if (rst && commit_wr) begin
            mem[commit_idx] <= commit_wdata;
        end
    end

    assign rdata  = rdata_q;
    assign halted = (state_q == S_HALTED);
    assign err    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = 16'd0;
    logic [15:0] req_wdata = 16'd0;
    logic        halt = 1'b0;

    logic        stall4, done4, halted4, err4;
    logic [15:0] rdata4;
    logic        stall1, done1, halted1, err1;
    logic [15:0] rdata1;

    logic        sel1 = 1'b0;
    logic        s_stall, s_done, s_halted, s_err;
    logic [15:0] s_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(4), .ADDR_W(10)) dut4 (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .halt(halt),
        .stall(stall4), .done(done4), .rdata(rdata4), .halted(halted4), .err(err4)
    );

    dmem_responder #(.LATENCY(1), .ADDR_W(10)) dut1 (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .halt(halt),
        .stall(stall1), .done(done1), .rdata(rdata1), .halted(halted1), .err(err1)
    );

    assign s_stall  = sel1 ? stall1  : stall4;
    assign s_done   = sel1 ? done1   : done4;
    assign s_halted = sel1 ? halted1 : halted4;
    assign s_err    = sel1 ? err1    : err4;
    assign s_rdata  = sel1 ? rdata1  : rdata4;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 16'd0;
        req_wdata = 16'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        halt = 1'b0;
        idle_inputs();
        #1;
        check("rst_stall", {15'd0, s_stall}, 16'd0);
        check("rst_done", {15'd0, s_done}, 16'd0);
        check("rst_rdata", s_rdata, 16'd0);
        check("rst_halted", {15'd0, s_halted}, 16'd0);
        check("rst_err", {15'd0, s_err}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Full access: accept cycle, LATENCY-1 busy cycles, then the done cycle.
    task automatic access(input logic rd, input logic [15:0] addr, input logic [15:0] wdata,
                          input int lat, input logic [15:0] exp_rdata);
        tick();
        req_rd = rd; req_wr = ~rd; req_addr = addr; req_wdata = wdata;
        #2;
        check("acc_stall", {15'd0, s_stall}, 16'd1);
        check("acc_done", {15'd0, s_done}, 16'd0);
        for (int i = 1; i < lat; i++) begin
            tick();
            req_rd = 1'b1; req_wr = 1'b1; req_addr = 16'hFFFF;
            #2;
            check("busy_stall", {15'd0, s_stall}, 16'd1);
            check("busy_done", {15'd0, s_done}, 16'd0);
        end
        tick();
        idle_inputs();
        #2;
        check("resp_done", {15'd0, s_done}, 16'd1);
        check("resp_stall", {15'd0, s_stall}, 16'd0);
        check("resp_err", {15'd0, s_err}, 16'd0);
        check("resp_rdata", s_rdata, exp_rdata);
    endtask

    initial begin
        do_reset();

        // Write then read back; rdata stays 0 across the write completion.
        access(1'b0, 16'h0010, 16'hBEEF, 4, 16'h0000);
        access(1'b1, 16'h0010, 16'h0000, 4, 16'hBEEF);

        // Aliasing: 0x0802 and 0x0002 map to the same word.
        access(1'b0, 16'h0802, 16'hA5A5, 4, 16'hBEEF);
        access(1'b1, 16'h0002, 16'h0000, 4, 16'hA5A5);

        // Odd address is rejected and err is sticky.
        tick();
        req_rd = 1'b1; req_addr = 16'h0011;
        #2;
        check("odd_stall", {15'd0, s_stall}, 16'd0);
        check("odd_err_early", {15'd0, s_err}, 16'd0);
        tick();
        idle_inputs();
        #2;
        check("odd_err", {15'd0, s_err}, 16'd1);
        check("odd_done", {15'd0, s_done}, 16'd0);
        for (int i = 0; i < 10; i++) tick();
        #2;
        check("odd_err_sticky", {15'd0, s_err}, 16'd1);

        // Simultaneous rd and wr on a fresh reset.
        do_reset();
        tick();
        req_rd = 1'b1; req_wr = 1'b1; req_addr = 16'h0010;
        #2;
        check("both_stall", {15'd0, s_stall}, 16'd0);
        tick();
        idle_inputs();
        #2;
        check("both_err", {15'd0, s_err}, 16'd1);
        check("both_done", {15'd0, s_done}, 16'd0);

        // Halt raised in the third busy cycle of a write.
        do_reset();
        tick();
        req_wr = 1'b1; req_addr = 16'h0020; req_wdata = 16'h00FF;
        #2;
        check("h_acc_stall", {15'd0, s_stall}, 16'd1);
        tick();
        idle_inputs();
        tick();
        tick();
        halt = 1'b1;
        #2;
        check("h_busy3_stall", {15'd0, s_stall}, 16'd1);
        tick();
        halt = 1'b0;
        #2;
        check("h_done", {15'd0, s_done}, 16'd1);
        check("h_not_yet", {15'd0, s_halted}, 16'd0);
        tick();
        req_rd = 1'b1; req_addr = 16'h0020;
        #2;
        check("h_halted", {15'd0, s_halted}, 16'd1);
        check("h_rd_stall", {15'd0, s_stall}, 16'd0);
        tick();
        #2;
        check("h_rd_done", {15'd0, s_done}, 16'd0);
        check("h_rd_err", {15'd0, s_err}, 16'd0);
        check("h_still", {15'd0, s_halted}, 16'd1);
        do_reset();
        access(1'b1, 16'h0020, 16'h0000, 4, 16'h00FF);

        // Asynchronous reset in the middle of a write drops it.
        access(1'b0, 16'h0030, 16'h1111, 4, 16'h00FF);
        tick();
        req_wr = 1'b1; req_addr = 16'h0030; req_wdata = 16'h7777;
        tick();
        idle_inputs();
        tick();
        #2;
        check("ar_busy_stall", {15'd0, s_stall}, 16'd1);
        check("ar_rdata_pre", s_rdata, 16'h00FF);
        rst = 1'b0;
        #1;
        check("ar_stall", {15'd0, s_stall}, 16'd0);
        check("ar_rdata", s_rdata, 16'h0000);
        check("ar_done", {15'd0, s_done}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        access(1'b1, 16'h0030, 16'h0000, 4, 16'h1111);

        // Halt alone in idle.
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        #2;
        check("idle_halt", {15'd0, s_halted}, 16'd1);

        // Single-cycle latency instance.
        sel1 = 1'b1;
        do_reset();
        access(1'b0, 16'h0004, 16'h1234, 1, 16'h0000);
        access(1'b1, 16'h0004, 16'h0000, 1, 16'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
